// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential two-digit packed-BCD to binary converter.
// Valid/ready handshake on both sides; the tens digit is multiplied by ten
// as (tens<<3) + (tens<<1) over two cycles, then the units digit is added.
// Optional feature macro: BCD_RANGE_CHECK_EN clamps legal results above
// MAX_VAL to MAX_VAL and flags err. Illegal digits always yield 8'hAA/err.
module bcd_to_binary_seq #(
    parameter int MAX_VAL = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Btemp_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] Dtemp_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        MUL8,
        MUL2,
        ADDU,
        OUT
    } state_t;

    localparam logic [7:0] MAX_CODE = 8'(MAX_VAL);
    localparam logic [7:0] BAD_CODE = 8'hAA;

`ifdef BCD_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    state_t     state;
    state_t     state_next;
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] acc;
    logic       digits_bad;
    logic [7:0] sum;
    logic       clamp;

    // Digit legality, final sum and optional clamp decision
    always_comb begin
        digits_bad = (tens > 4'd9) || (units > 4'd9);
        sum        = acc + {4'b0000, units};
        clamp      = RANGE_EN && (sum > MAX_CODE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and input-side ready
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CHK;
                end
            end
            CHK:  state_next = digits_bad ? OUT : MUL8;
            MUL8: state_next = MUL2;
            MUL2: state_next = ADDU;
            ADDU: state_next = OUT;
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: digit capture, accumulation and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens      <= '0;
            units     <= '0;
            acc       <= '0;
            Dtemp_out <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tens  <= Btemp_in[7:4];
                        units <= Btemp_in[3:0];
                        err   <= 1'b0;
                    end
                end
                CHK: begin
                    if (digits_bad) begin
                        Dtemp_out <= BAD_CODE;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                    end else begin
                        acc <= '0;
                    end
                end
                MUL8: acc <= {1'b0, tens, 3'b000};
                MUL2: acc <= acc + {3'b000, tens, 1'b0};
                ADDU: begin
                    acc       <= sum;
                    Dtemp_out <= clamp ? MAX_CODE : sum;
                    err       <= clamp;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (instantiated with MAX_VAL=85).
// Expected results come from decimal arithmetic on the BCD digits.
module tb_bcd_to_binary_seq;

    localparam int MAXV = 85;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] Btemp_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] Dtemp_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err;

    int checks   = 0;
    int failures = 0;

    bcd_to_binary_seq #(.MAX_VAL(MAXV)) dut (
        .clk       (clk),
        .rst       (rst),
        .Btemp_in  (Btemp_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Dtemp_out (Dtemp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of two BCD digits, illegal digits -> AA/err
    task automatic model(input logic [7:0] b, output logic [7:0] d, output logic e,
                         output int lat);
        int t;
        int u;
        int v;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        if (t > 9 || u > 9) begin
            d = 8'hAA; e = 1'b1; lat = 2;
        end else begin
            v = t * 10 + u;
            d = 8'(v); e = 1'b0; lat = 5;
`ifdef BCD_RANGE_CHECK_EN
            if (v > MAXV) begin
                d = 8'(MAXV); e = 1'b1;
            end
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles out_ready stays low in OUT
    task automatic xact(input logic [7:0] b, input int unsigned hold);
        logic [7:0] ed;
        logic       ee;
        int         elat;
        int         lat;
        int         w;
        model(b, ed, ee, elat);
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        Btemp_in  = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        Btemp_in = 8'($urandom);
        chk("err_cleared", {31'b0, err}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        chk($sformatf("latency_%h", b), lat, elat);
        chk($sformatf("data_%h", b), {24'b0, Dtemp_out}, {24'b0, ed});
        chk($sformatf("err_%h", b), {31'b0, err}, {31'b0, ee});
        for (int unsigned i = 0; i < hold; i++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", {24'b0, Dtemp_out}, {24'b0, ed});
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("out_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("post_hs_valid", {31'b0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] res[$];
        logic [7:0] pre_d;
        logic       pre_ir;
        logic       pre_ov;
        int         acc_cnt;
        int         quiet;

        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {24'b0, Dtemp_out}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        step();

        // Directed cases
        xact(8'h72, 0);
        xact(8'h3C, 0);
        xact(8'hA5, 0);
        xact(8'h90, 0);
        xact(8'h99, 10);
        xact(8'h85, 2);
        xact(8'h86, 0);

        // Back-to-back with in_valid held high
        Btemp_in  = 8'h00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc_cnt   = 0;
        for (int c = 0; c < 30; c++) begin
            pre_ir = in_ready;
            pre_ov = out_valid;
            pre_d  = Dtemp_out;
            step();
            if (pre_ir && in_valid) begin
                acc_cnt++;
                if (acc_cnt == 1) Btemp_in = 8'h09;
                else in_valid = 1'b0;
            end
            if (pre_ov) res.push_back(pre_d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", acc_cnt, 32'd2);
        chk("b2b_results", res.size(), 32'd2);
        if (res.size() == 2) begin
            chk("b2b_first", {24'b0, res[0]}, 32'd0);
            chk("b2b_second", {24'b0, res[1]}, 32'd9);
        end

        // Reset between edges while in MUL2
        xact(8'h72, 0);
        Btemp_in = 8'h58;
        in_valid = 1'b1;
        step();            // accepted -> CHK
        in_valid = 1'b0;
        step();            // -> MUL8
        step();            // -> MUL2
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_data", {24'b0, Dtemp_out}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        #3;
        rst = 1'b0;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) quiet++;
        end
        chk("midrst_no_output", quiet, 32'd0);
        xact(8'h45, 0);

        // Randomized traffic, biased toward legal digits
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            b[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            b[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            xact(b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_to_binary_seq.md
BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001 SHALL have parameter MAX_VAL, default 99: largest legal binary result, range 0..99.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Btemp_in, input, 8 bits: packed BCD, [7:4] tens digit, [3:0] units digit.
REQ-005 SHALL have port in_valid, input, 1 bit: Btemp_in is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an input.
REQ-007 SHALL have port Dtemp_out, output, 8 bits: binary result.
REQ-008 SHALL have port out_valid, output, 1 bit: Dtemp_out and err are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port err, output, 1 bit: result is an error or was clamped; qualified by out_valid.

Function
REQ-011 SHALL use FSM states IDLE, CHK, MUL8, MUL2, ADDU and OUT, one cycle each except OUT.
REQ-012 SHALL drive in_ready=1 only in IDLE; an input is accepted on an edge where in_valid=1 and in_ready=1.
REQ-013 SHALL register both digits on acceptance and go IDLE->CHK; later changes on Btemp_in have no effect until the next acceptance.
REQ-014 CHK SHALL go to OUT with Dtemp_out=8'hAA and err=1 if either digit is >9; otherwise it SHALL clear the accumulator and go to MUL8.
REQ-015 MUL8 SHALL set acc=tens<<3; MUL2 SHALL do acc+=tens<<1; ADDU SHALL do acc+=units and then go to OUT.
REQ-016 SHALL keep the accumulator 8 bits wide; the largest legal value is 99, so it never overflows.
REQ-017 SHALL assert out_valid on the 5th rising edge after acceptance for legal digits, and on the 2nd edge for illegal digits.
REQ-018 SHALL hold Dtemp_out, err and out_valid stable in OUT while out_ready=0.
REQ-019 SHALL leave OUT for IDLE on an edge where out_valid=1 and out_ready=1, clearing out_valid in the same edge.
REQ-020 SHALL NOT accept a new input in the cycle the output handshake completes: in_ready rises one cycle later.
REQ-021 If out_ready is already 1 when OUT is entered, SHALL keep out_valid high for exactly one cycle.
REQ-022 SHALL clear err on every acceptance.

Reset
REQ-023 SHALL force state=IDLE, Dtemp_out=0, err=0, out_valid=0 and acc=0 immediately on rst=1, independent of clk.
REQ-024 SHALL drive in_ready=1 while in reset and after reset.
REQ-025 Reset asserted mid-conversion or in OUT SHALL discard the operation with no output handshake; the first edge after release behaves as IDLE.

Configuration
REQ-026 Macro BCD_RANGE_CHECK_EN SHALL control range checking.
REQ-027 With BCD_RANGE_CHECK_EN defined, a legal-digit result > MAX_VAL SHALL give Dtemp_out=MAX_VAL, err=1.
REQ-028 Without BCD_RANGE_CHECK_EN, legal-digit results SHALL pass unclamped with err=0; MAX_VAL is then unused.
REQ-029 Illegal-digit handling (REQ-014) SHALL be identical with or without BCD_RANGE_CHECK_EN.

Verification
REQ-030 Btemp_in=8'h72, in_valid pulse, out_ready=1 -> out_valid for 1 cycle, 5 edges after acceptance, Dtemp_out=8'd72, err=0.
REQ-031 Btemp_in=8'h3C -> out_valid 2 edges after acceptance, Dtemp_out=8'hAA, err=1; same for 8'hA5.
REQ-032 MAX_VAL=85, BCD_RANGE_CHECK_EN defined, Btemp_in=8'h90 -> Dtemp_out=85, err=1; without the macro -> Dtemp_out=90, err=0.
REQ-033 Btemp_in=8'h99, out_ready=0 for 10 cycles -> Dtemp_out=99 and out_valid held stable, in_ready=0; out_ready=1 -> in_ready=1 on the following cycle.
REQ-034 Btemp_in=8'h00 then 8'h09 back-to-back with in_valid held high -> two results, 0 then 9, with no input dropped or duplicated.
REQ-035 rst pulsed between clock edges during MUL2 -> outputs go to 0 immediately, no out_valid, in_ready=1; next input 8'h45 -> 45.
